// File: rtl/sample_tick_gen.sv
// Programmable sampling-strobe generator: one-clock strobe every div_cur+1 clocks,
// continuous or fixed-length burst, with glitch-free divisor updates at period boundaries.
module sample_tick_gen #(
  parameter int unsigned CNT_W   = 17,
  parameter int unsigned DEF_DIV = 5000,
  parameter int unsigned BURST_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic               start,
  input  logic [BURST_W-1:0] burst_len,
  input  logic [CNT_W-1:0]   div_in,
  input  logic               div_load,
  output logic               sclk,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   div_cur
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BURST = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   div_q, div_d;
  logic [CNT_W-1:0]   pend_div_q, pend_div_d;
  logic               pend_vld_q, pend_vld_d;
  logic [BURST_W-1:0] bcnt_q, bcnt_d;
  logic               sclk_q, sclk_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic wrap;
  assign wrap = (count_q == div_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      div_q      <= CNT_W'(DEF_DIV);
      pend_div_q <= '0;
      pend_vld_q <= 1'b0;
      bcnt_q     <= '0;
      sclk_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      div_q      <= div_d;
      pend_div_q <= pend_div_d;
      pend_vld_q <= pend_vld_d;
      bcnt_q     <= bcnt_d;
      sclk_q     <= sclk_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state, counter, divisor hand-over and burst bookkeeping.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    div_d      = div_q;
    pend_div_d = pend_div_q;
    pend_vld_d = pend_vld_q;
    bcnt_d     = bcnt_q;
    sclk_d     = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;

    if (div_load) begin
      pend_div_d = div_in;
      pend_vld_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        count_d = '0;
        busy_d  = 1'b0;
        if (div_load) begin
          div_d      = div_in;
          pend_vld_d = 1'b0;
        end
        if (en) begin
          if (!mode) begin
            state_d = ST_RUN;
            busy_d  = 1'b1;
          end else if (start) begin
            if (burst_len == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = ST_BURST;
              busy_d  = 1'b1;
              bcnt_d  = burst_len;
            end
          end
        end
      end

      ST_RUN, ST_BURST: begin
        if (!en || wrap) begin
          // Period boundary or exit: adopt the newest divisor request.
          count_d = '0;
          if (div_load) begin
            div_d      = div_in;
            pend_vld_d = 1'b0;
          end else if (pend_vld_q) begin
            div_d      = pend_div_q;
            pend_vld_d = 1'b0;
          end
        end else begin
          count_d = count_q + CNT_W'(1);
        end

        if (!en) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else if (wrap) begin
          sclk_d = 1'b1;
          if (state_q == ST_BURST) begin
            bcnt_d = bcnt_q - BURST_W'(1);
            if (bcnt_q == BURST_W'(1)) begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        count_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign sclk    = sclk_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign div_cur = div_q;

endmodule

// File: tb/tb_sample_tick_gen.sv
// Scoreboard bench for sample_tick_gen: per-edge expectations are queued with the
// stimulus and compared by a monitor 1 time unit after each rising edge.
module tb_sample_tick_gen;

  logic        clk;
  logic        rst;
  logic        en;
  logic        mode;
  logic        start;
  logic [9:0]  burst_len;
  logic [16:0] div_in;
  logic        div_load;
  logic        sclk;
  logic        busy;
  logic        done;
  logic [16:0] div_cur;

  typedef struct {
    string       tag;
    logic        s;
    logic        b;
    logic        d;
    logic [16:0] dv;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  sample_tick_gen #(
    .CNT_W  (17),
    .DEF_DIV(3),
    .BURST_W(10)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .start    (start),
    .burst_len(burst_len),
    .div_in   (div_in),
    .div_load (div_load),
    .sclk     (sclk),
    .busy     (busy),
    .done     (done),
    .div_cur  (div_cur)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Queue the outputs expected after the next rising edge, then advance to the falling edge.
  task automatic tick(input string tag, input logic s, input logic b, input logic d,
                      input logic [16:0] dv);
    exp_t e;
    e.tag = tag;
    e.s   = s;
    e.b   = b;
    e.d   = d;
    e.dv  = dv;
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check({e.tag, "_sclk"}, 32'(sclk), 32'(e.s));
      check({e.tag, "_busy"}, 32'(busy), 32'(e.b));
      check({e.tag, "_done"}, 32'(done), 32'(e.d));
      check({e.tag, "_div"},  32'(div_cur), 32'(e.dv));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    en        = 1'b0;
    mode      = 1'b0;
    start     = 1'b0;
    burst_len = '0;
    div_in    = '0;
    div_load  = 1'b0;
    #12;
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_div",  32'(div_cur), 32'd3);
    @(negedge clk);
    rst = 1'b0;

    // Continuous DIV=3, divisor change to 1 requested mid-period at edge 6.
    en   = 1'b1;
    mode = 1'b0;
    for (int k = 0; k <= 14; k++) begin
      div_load = (k == 6);
      div_in   = 17'd1;
      tick($sformatf("run_e%0d", k),
           (k == 4 || k == 8 || k == 10 || k == 12 || k == 14), 1'b1, 1'b0,
           (k < 8) ? 17'd3 : 17'd1);
    end
    div_load = 1'b0;
    en       = 1'b0;
    tick("run_exit", 1'b0, 1'b0, 1'b0, 17'd1);

    // Burst DIV=2 len=4; a second start mid-burst must be ignored.
    div_load = 1'b1;
    div_in   = 17'd2;
    tick("b4_ld", 1'b0, 1'b0, 1'b0, 17'd2);
    div_load = 1'b0;
    en       = 1'b1;
    mode     = 1'b1;
    for (int k = 0; k <= 15; k++) begin
      start     = (k == 0 || k == 5);
      burst_len = (k == 5) ? 10'd1 : 10'd4;
      tick($sformatf("b4_e%0d", k),
           (k == 3 || k == 6 || k == 9 || k == 12), (k < 12), (k == 12), 17'd2);
    end

    // Zero-length burst: done only, no strobes.
    start     = 1'b1;
    burst_len = 10'd0;
    tick("b0_e0", 1'b0, 1'b0, 1'b1, 17'd2);
    start = 1'b0;
    for (int k = 1; k <= 3; k++)
      tick($sformatf("b0_e%0d", k), 1'b0, 1'b0, 1'b0, 17'd2);

    // Burst DIV=3 len=8 aborted by en=0; pending divisor 1 applied on exit.
    en       = 1'b0;
    div_load = 1'b1;
    div_in   = 17'd3;
    tick("ab_ld", 1'b0, 1'b0, 1'b0, 17'd3);
    mode      = 1'b1;
    burst_len = 10'd8;
    for (int k = 0; k <= 7; k++) begin
      start    = (k == 0);
      en       = (k < 6);
      div_load = (k == 5);
      div_in   = 17'd1;
      tick($sformatf("ab_e%0d", k), (k == 4), (k < 6), 1'b0, (k < 6) ? 17'd3 : 17'd1);
    end
    div_load = 1'b0;

    // Restart delivers the full 8 strobes at DIV=1.
    en = 1'b1;
    for (int k = 0; k <= 19; k++) begin
      start = (k == 0);
      tick($sformatf("rs_e%0d", k),
           (k >= 2 && k <= 16 && (k % 2) == 0), (k < 16), (k == 16), 17'd1);
    end

    // Async reset right after a strobe, between edges.
    mode = 1'b0;
    tick("ar_e0", 1'b0, 1'b1, 1'b0, 17'd1);
    tick("ar_e1", 1'b0, 1'b1, 1'b0, 17'd1);
    tick("ar_e2", 1'b1, 1'b1, 1'b0, 17'd1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_sclk", 32'(sclk), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_done", 32'(done), 32'd0);
    check("ar_div",  32'(div_cur), 32'd3);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;

    // DIV=0: strobe every clock while running.
    div_load = 1'b1;
    div_in   = 17'd0;
    tick("d0_ld", 1'b0, 1'b0, 1'b0, 17'd0);
    div_load = 1'b0;
    en       = 1'b1;
    mode     = 1'b0;
    for (int k = 0; k <= 6; k++)
      tick($sformatf("d0_e%0d", k), (k >= 1), 1'b1, 1'b0, 17'd0);
    en = 1'b0;
    tick("d0_exit", 1'b0, 1'b0, 1'b0, 17'd0);

    @(posedge clk);
    #2;
    check("q_empty", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
